// File: rtl/stream_pkg.sv
// Shared definitions for the stream_* family of handshake blocks.
package stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/stream_narrow.sv
// Width converter: splits one WIDTH*RATIO-bit input word into RATIO beats of
// WIDTH bits, least-significant slice first, with valid/ready on both sides.
module stream_narrow
  import stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [WIDTH*RATIO-1:0] in,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       out,
  output logic                   o_last
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  typedef logic [RATIO-1:0][WIDTH-1:0] word_t;

  function automatic logic is_last_idx(input logic [CW-1:0] idx);
    return idx == LAST_IDX;
  endfunction

  state_e          state_p1;
  word_t           word_p1;
  logic [CW-1:0]   cnt_p1;
  logic [CW-1:0]   cnt_nxt;
  logic [WIDTH-1:0] out_p1;
  logic            last_p1;
  logic            in_hs;
  logic            out_hs;

  // A new word may enter while idle, or in the same cycle the last beat leaves.
  assign o_ready = !srst && (!o_valid || (i_ready && o_last));
  assign in_hs   = i_valid && o_ready;
  assign out_hs  = o_valid && i_ready;
  assign cnt_nxt = cnt_p1 + CW'(1);

  // ---- stage p1: held word, beat counter and registered outputs ----
  always_ff @(posedge clk) begin
    if (srst) begin
      state_p1 <= IDLE;
      word_p1  <= '0;
      cnt_p1   <= '0;
      out_p1   <= '0;
      last_p1  <= 1'b0;
    end else if (in_hs) begin
      state_p1 <= BUSY;
      word_p1  <= word_t'(in);
      cnt_p1   <= '0;
      out_p1   <= in[WIDTH-1:0];
      last_p1  <= is_last_idx('0);
    end else if (out_hs) begin
      if (last_p1) begin
        state_p1 <= IDLE;
        cnt_p1   <= '0;
        out_p1   <= '0;
        last_p1  <= 1'b0;
      end else begin
        cnt_p1  <= cnt_nxt;
        out_p1  <= word_p1[cnt_nxt];
        last_p1 <= is_last_idx(cnt_nxt);
      end
    end
  end

  assign o_valid = (state_p1 == BUSY);
  assign out     = out_p1;
  assign o_last  = last_p1;

endmodule

// File: doc/stream_narrow.md
STREAM_NARROW -- requirements
Module: stream_narrow

Interface
REQ-001 Parameter WIDTH, default 8: width of one output beat in bits; SHALL be >= 1.
REQ-002 Parameter RATIO, default 4: number of output beats per input word; SHALL be >= 2.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 srst  input  1  reset; synchronous, active-high.
REQ-005 i_valid  input  1  upstream word on `in` is valid.
REQ-006 o_ready  output  1  block accepts an input word this cycle.
REQ-007 in  input  WIDTH*RATIO  wide input word.
REQ-008 o_valid  output  1  beat on `out` is valid.
REQ-009 i_ready  input  1  downstream accepts the beat this cycle.
REQ-010 out  output  WIDTH  narrow output beat.
REQ-011 o_last  output  1  the current beat is the final beat of its word.

Function
REQ-012 Input handshake SHALL occur when i_valid && o_ready at a rising edge; output handshake SHALL occur when o_valid && i_ready.
REQ-013 Beat order SHALL be LSB slice first: beat k = in[k*WIDTH +: WIDTH], k = 0..RATIO-1.
REQ-014 States: IDLE (o_valid=0) and BUSY (o_valid=1, beat counter 0..RATIO-1).
REQ-015 Transitions:
- IDLE -> BUSY on input handshake, with counter = 0.
- In BUSY, a non-last output handshake SHALL increment the counter.
- Last-beat handshake plus a simultaneous input handshake SHALL reload the word, stay in BUSY and set counter = 0.
- Last-beat handshake with no input handshake SHALL go to IDLE.
REQ-016 Latency: beat 0 SHALL appear on `out` with o_valid=1 in the cycle after the input handshake.
REQ-017 o_ready SHALL be combinational: !srst && (!o_valid || (i_ready && o_last)).
- This gives 100% throughput with back-to-back words and no bubble beats.
- The i_ready-to-o_ready combinational path is intended.
REQ-018 out, o_valid and o_last SHALL be driven from registers, with no combinational path from in or i_valid.
REQ-019 While o_valid && !i_ready, out, o_last and the counter SHALL hold stable, and o_valid SHALL stay 1.
REQ-020 o_last SHALL be 1 exactly when o_valid=1 and counter = RATIO-1, and 0 otherwise.
REQ-021 The captured word SHALL be held internally; `in` is don't-care outside the input handshake cycle.
REQ-022 The counter width SHALL be $clog2(RATIO) bits; the counter SHALL never exceed RATIO-1, including for non-power-of-two RATIO.
REQ-023 When o_valid=0, out SHALL be 0.

Reset
REQ-024 While srst=1: o_ready=0 (combinational), and at the edge o_valid=0, o_last=0, out=0, counter=0, held word=0.
REQ-025 Reset mid-word SHALL discard the remaining beats; after srst deasserts the block SHALL be in IDLE with o_ready=1.

Structure
REQ-026 The shared package stream_pkg SHALL hold the state enum (IDLE, BUSY) for reuse by stream blocks; the module SHALL take no other typedefs from it.
REQ-027 No sub-module is required. Integrators SHALL place skid_buf externally if o_ready timing closure demands it.

Verification (WIDTH=8, RATIO=4)
REQ-028 Single word: in=0x44332211, i_ready=1 -> out 0x11,0x22,0x33,0x44 on cycles 1-4, o_last only on 0x44, o_ready=0 during cycles 1-3.
REQ-029 Back-to-back: 0x44332211 then 0x88776655, i_valid=1 and i_ready=1 throughout -> 8 consecutive beats 0x11..0x88 with no gap; the second word is accepted in the same cycle as beat 0x44.
REQ-030 Backpressure: i_ready=0 for 3 cycles while out=0x22 -> out=0x22, o_valid=1 and o_last=0 held; 0x33 follows after i_ready returns.
REQ-031 Reset mid-word: srst pulsed for 1 cycle after beat 0x11 -> next cycle o_valid=0 and o_ready=1; a new word 0xDDCCBBAA yields 0xAA first.
REQ-032 Random stress: 1000 random words with random i_valid and i_ready (50% each) -> scoreboard matches LSB-first order, exactly one o_last per word, and no beat changes while stalled.
